solution_collector: RTL and testbench

- Sits directly downstream of the hash validator in the mining core.
- Each cycle the core may present one finished hash candidate: its nonce, plus the validator's combinational `valid` verdict (meets difficulty).
- Block counts candidates and hits, and buffers winning nonces in a small first-word-fall-through (FWFT) FIFO.
- Host drains the FIFO over a valid/ready handshake. The hash pipeline never stalls; loss is flagged instead.

---
 rtl/solution_collector_if.sv | 33 +++
 rtl/solution_collector.sv | 160 ++++++++++++++++
 tb/tb_solution_collector.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/solution_collector_if.sv
// Bus between the mining core, the host and solution_collector.
// Carries the run control pulses, the candidate stream from the hash
// validator, the FWFT drain handshake and the statistics outputs.
// Clock and reset are not part of this bundle.
interface solution_collector_if #(
   parameter int NONCE_W = 32,
   parameter int CNT_W   = 32
);
   logic               start;
   logic               stop;
   logic               in_valid;
   logic [NONCE_W-1:0] in_nonce;
   logic               in_hash_ok;
   logic               out_valid;
   logic [NONCE_W-1:0] out_nonce;
   logic               out_ready;
   logic               busy;
   logic               overflow;
   logic [CNT_W-1:0]   hashes_checked;
   logic [CNT_W-1:0]   solutions_found;

   // Core/host side: drives control, candidates and the drain ready.
   modport master (
      output start, stop, in_valid, in_nonce, in_hash_ok, out_ready,
      input  out_valid, out_nonce, busy, overflow, hashes_checked, solutions_found
   );

   // Collector side.
   modport slave (
      input  start, stop, in_valid, in_nonce, in_hash_ok, out_ready,
      output out_valid, out_nonce, busy, overflow, hashes_checked, solutions_found
   );
endinterface

// File: rtl/solution_collector.sv
// solution_collector: counts hash candidates and hits while in RUN and
// buffers winning nonces in a small first-word-fall-through FIFO that the
// host drains over a valid/ready handshake. The hash pipeline never stalls;
// a hit arriving at a full FIFO is dropped and flagged by sticky overflow.
//
// Optional build macro SOLUTION_COLLECTOR_HIT_STOP_EN: the first hit that
// is actually stored returns the block to IDLE, so later candidates are
// ignored until the next start. Ports are identical in both builds.
module solution_collector #(
   parameter int NONCE_W = 32,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 32
) (
   input logic                clk,
   input logic                rst_n,
   solution_collector_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [AW:0]        rdPtr_q, rdPtr_d;
   logic [AW:0]        wrPtr_q, wrPtr_d;
   logic               overflow_q, overflow_d;
   logic [CNT_W-1:0]   hashes_q, hashes_d;
   logic [CNT_W-1:0]   solutions_q, solutions_d;
   logic [NONCE_W-1:0] mem_q [DEPTH];

   logic fifoEmpty;
   logic fifoFull;
   logic runCycle;
   logic candidate;
   logic hit;
   logic pop;
   logic push;
   logic drop;

   // Handshake decode. The start cycle itself never counts or stores:
   // its candidate is discarded because the clear wins.
   always_comb begin
      fifoEmpty = (rdPtr_q == wrPtr_q);
      fifoFull  = (rdPtr_q[AW] != wrPtr_q[AW]) &&
                  (rdPtr_q[AW-1:0] == wrPtr_q[AW-1:0]);
      runCycle  = (state_q == RUN) && !bus.start;
      candidate = runCycle && bus.in_valid;
      hit       = candidate && bus.in_hash_ok;
      pop       = !fifoEmpty && bus.out_ready;
      push      = hit && (!fifoFull || pop);
      drop      = hit && fifoFull && !pop;
   end

   // Run control: start always wins over stop and re-clears while running.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.start) begin
               state_d = RUN;
            end else if (bus.stop) begin
               state_d = IDLE;
`ifdef SOLUTION_COLLECTOR_HIT_STOP_EN
            end else if (push) begin
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO pointers: flush on start, otherwise advance on pop/push.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      if (bus.start) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
      end else begin
         if (pop) begin
            rdPtr_d = rdPtr_q + (AW+1)'(1);
         end
         if (push) begin
            wrPtr_d = wrPtr_q + (AW+1)'(1);
         end
      end
   end

   // Statistics: saturating counters and sticky overflow, cleared on start.
   always_comb begin
      hashes_d    = hashes_q;
      solutions_d = solutions_q;
      overflow_d  = overflow_q;
      if (bus.start) begin
         hashes_d    = '0;
         solutions_d = '0;
         overflow_d  = 1'b0;
      end else begin
         if (candidate && (hashes_q != '1)) begin
            hashes_d = hashes_q + CNT_W'(1);
         end
         if (hit && (solutions_q != '1)) begin
            solutions_d = solutions_q + CNT_W'(1);
         end
         if (drop) begin
            overflow_d = 1'b1;
         end
      end
   end

   // State, pointer and statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rdPtr_q     <= '0;
         wrPtr_q     <= '0;
         overflow_q  <= 1'b0;
         hashes_q    <= '0;
         solutions_q <= '0;
      end else begin
         state_q     <= state_d;
         rdPtr_q     <= rdPtr_d;
         wrPtr_q     <= wrPtr_d;
         overflow_q  <= overflow_d;
         hashes_q    <= hashes_d;
         solutions_q <= solutions_d;
      end
   end

   // FIFO storage; cleared on reset so the head is never X when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wrPtr_q[AW-1:0]] <= bus.in_nonce;
      end
   end

   // Outputs come straight from registers; the head is read FWFT-style.
   always_comb begin
      bus.out_valid       = !fifoEmpty;
      bus.out_nonce       = mem_q[rdPtr_q[AW-1:0]];
      bus.busy            = (state_q == RUN);
      bus.overflow        = overflow_q;
      bus.hashes_checked  = hashes_q;
      bus.solutions_found = solutions_q;
   end

endmodule

// File: tb/tb_solution_collector.sv
// Directed, table-driven bench for solution_collector with DEPTH=4 and
// 4-bit counters so that counter saturation is reachable in a few cycles.
// Each table row is one clock: inputs driven at the falling edge, outputs
// compared 1 time unit after the rising edge.
module tb_solution_collector;

   localparam int NONCE_W = 32;
   localparam int DEPTH   = 4;
   localparam int CNT_W   = 4;

   typedef struct {
      logic        start;
      logic        stop;
      logic        inValid;
      logic [31:0] nonce;
      logic        hashOk;
      logic        outReady;
      logic        expValid;
      logic [31:0] expNonce;
      logic        expBusy;
      logic        expOverflow;
      int          expHashes;
      int          expSolutions;
   } vec_t;

   logic clk;
   logic rst_n;
   int   testsRun;
   int   testsFailed;
   vec_t vecs[$];

   solution_collector_if #(.NONCE_W(NONCE_W), .CNT_W(CNT_W)) bus ();

   solution_collector #(
      .NONCE_W(NONCE_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic addRow(input logic st, input logic sp, input logic iv, input logic [31:0] n,
                         input logic ok, input logic rdy, input logic ev, input logic [31:0] en,
                         input logic eb, input logic eo, input int eh, input int es);
      vec_t v;
      v.start = st; v.stop = sp; v.inValid = iv; v.nonce = n; v.hashOk = ok;
      v.outReady = rdy; v.expValid = ev; v.expNonce = en; v.expBusy = eb;
      v.expOverflow = eo; v.expHashes = eh; v.expSolutions = es;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.start      = v.start;
      bus.stop       = v.stop;
      bus.in_valid   = v.inValid;
      bus.in_nonce   = v.nonce;
      bus.in_hash_ok = v.hashOk;
      bus.out_ready  = v.outReady;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("row%0d", idx);
      checkVal({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v.expValid));
      if (v.expValid) begin
         checkVal({tag, ".out_nonce"}, bus.out_nonce, v.expNonce);
      end
      checkVal({tag, ".busy"}, 32'(bus.busy), 32'(v.expBusy));
      checkVal({tag, ".overflow"}, 32'(bus.overflow), 32'(v.expOverflow));
      checkVal({tag, ".hashes_checked"}, 32'(bus.hashes_checked), 32'(v.expHashes));
      checkVal({tag, ".solutions_found"}, 32'(bus.solutions_found), 32'(v.expSolutions));
   endtask

   task automatic idleInputs();
      bus.start      = 1'b0;
      bus.stop       = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_nonce   = '0;
      bus.in_hash_ok = 1'b0;
      bus.out_ready  = 1'b0;
   endtask

   // Main sequence: build the vector table, reset, run the table, then the
   // hand-written asynchronous reset scenario.
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst_n       = 1'b0;
      idleInputs();

`ifndef SOLUTION_COLLECTOR_HIT_STOP_EN
      // IDLE ignores candidates; start discards its own candidate.
      addRow(0,0,1,32'h99,1,0, 0,0,0,0, 0,0);
      addRow(1,0,1,32'hAA,1,0, 0,0,1,0, 0,0);
      // Ten misses are counted, nothing stored.
      for (int k = 1; k <= 10; k++) addRow(0,0,1,k,0,0, 0,0,1,0, k,0);
      // Three hits held with out_ready low, then drained in order.
      addRow(1,0,0,0,0,0, 0,0,1,0, 0,0);
      addRow(0,0,1,32'h11,1,0, 1,32'h11,1,0, 1,1);
      addRow(0,0,1,32'h22,1,0, 1,32'h11,1,0, 2,2);
      addRow(0,0,1,32'h33,1,0, 1,32'h11,1,0, 3,3);
      addRow(0,0,0,0,0,1, 1,32'h22,1,0, 3,3);
      addRow(0,0,0,0,0,1, 1,32'h33,1,0, 3,3);
      addRow(0,0,0,0,0,1, 0,0,1,0, 3,3);
      addRow(0,0,0,0,0,1, 0,0,1,0, 3,3);
      // Push into empty FIFO with out_ready high: no pop that cycle.
      addRow(0,0,1,32'h44,1,1, 1,32'h44,1,0, 4,4);
      addRow(0,0,0,0,0,1, 0,0,1,0, 4,4);
      // Overfill: hits 1..6, entries 5 and 6 dropped.
      addRow(1,0,0,0,0,0, 0,0,1,0, 0,0);
      for (int k = 1; k <= 6; k++) addRow(0,0,1,k,1,0, 1,1,1,(k >= 5), k,k);
      // stop keeps the FIFO; drain in IDLE while an ignored hit arrives.
      addRow(0,1,0,0,0,0, 1,1,0,1, 6,6);
      addRow(0,0,1,32'hEE,1,1, 1,2,0,1, 6,6);
      addRow(0,0,0,0,0,1, 1,3,0,1, 6,6);
      addRow(0,0,0,0,0,1, 1,4,0,1, 6,6);
      addRow(0,0,0,0,0,1, 0,0,0,1, 6,6);
      // start clears overflow, counters and FIFO.
      addRow(1,0,0,0,0,0, 0,0,1,0, 0,0);
      // Full FIFO with push and pop together: both succeed.
      for (int k = 1; k <= 4; k++) addRow(0,0,1,k,1,0, 1,1,1,0, k,k);
      addRow(0,0,1,5,1,1, 1,2,1,0, 5,5);
      addRow(0,0,0,0,0,1, 1,3,1,0, 5,5);
      addRow(0,0,0,0,0,1, 1,4,1,0, 5,5);
      addRow(0,0,0,0,0,1, 1,5,1,0, 5,5);
      addRow(0,0,0,0,0,1, 0,0,1,0, 5,5);
      // start and stop with a hit in the same cycle: start wins, no push.
      addRow(0,0,1,32'h66,1,0, 1,32'h66,1,0, 6,6);
      addRow(1,1,1,32'h55,1,0, 0,0,1,0, 0,0);
      addRow(0,0,0,0,0,1, 0,0,1,0, 0,0);
      // Counter saturation at 15 for both counters.
      for (int k = 1; k <= 17; k++)
         addRow(0,0,1,k,1,0, 1,1,1,(k >= 5), (k > 15) ? 15 : k, (k > 15) ? 15 : k);
      addRow(0,1,0,0,0,0, 1,1,0,1, 15,15);
`else
      // First stored hit stops the block; the next hit is ignored.
      addRow(1,0,0,0,0,0, 0,0,1,0, 0,0);
      addRow(0,0,1,7,1,0, 1,7,0,0, 1,1);
      addRow(0,0,1,8,1,0, 1,7,0,0, 1,1);
      addRow(0,0,0,0,0,1, 0,0,0,0, 1,1);
      // A miss keeps running; the following hit stops it.
      addRow(1,0,0,0,0,0, 0,0,1,0, 0,0);
      addRow(0,0,1,9,0,0, 0,0,1,0, 1,0);
      addRow(0,0,1,32'h10,1,1, 1,32'h10,0,0, 2,1);
      addRow(0,0,0,0,0,1, 0,0,0,0, 2,1);
`endif

      // Reset values while reset is held.
      #12;
      checkVal("reset.out_valid", 32'(bus.out_valid), 32'd0);
      checkVal("reset.out_nonce", bus.out_nonce, 32'd0);
      checkVal("reset.busy", 32'(bus.busy), 32'd0);
      checkVal("reset.overflow", 32'(bus.overflow), 32'd0);
      checkVal("reset.hashes_checked", 32'(bus.hashes_checked), 32'd0);
      checkVal("reset.solutions_found", 32'(bus.solutions_found), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1;
         checkOutput(vecs[i], i);
      end

      // Asynchronous reset in the middle of a drain.
      @(negedge clk);
      idleInputs();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start      = 1'b0;
      bus.in_valid   = 1'b1;
      bus.in_hash_ok = 1'b1;
      bus.in_nonce   = 32'hA1;
      @(negedge clk);
      bus.in_nonce   = 32'hA2;
      @(negedge clk);
      idleInputs();
      bus.out_ready = 1'b1;
      checkVal("drain.out_valid_before_reset", 32'(bus.out_valid), 32'd1);
      checkVal("drain.out_nonce_before_reset", bus.out_nonce, 32'hA1);
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("async_reset.out_valid", 32'(bus.out_valid), 32'd0);
      checkVal("async_reset.out_nonce", bus.out_nonce, 32'd0);
      checkVal("async_reset.busy", 32'(bus.busy), 32'd0);
      checkVal("async_reset.hashes_checked", 32'(bus.hashes_checked), 32'd0);
      checkVal("async_reset.solutions_found", 32'(bus.solutions_found), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkVal("post_reset.out_valid", 32'(bus.out_valid), 32'd0);
      checkVal("post_reset.busy", 32'(bus.busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
